// File: rtl/dawg_cache_set_pkg.sv
// dawg_cache_set_pkg: FSM encodings, default geometry and width helper shared by the DAWG set.
package dawg_cache_set_pkg;
    localparam int DEF_NUM_WAYS    = 4;
    localparam int DEF_NUM_DOMAINS = 2;
    localparam int DEF_ADDR_WIDTH  = 32;
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_OS_UPD = 2'd1;
    localparam logic [1:0] S_LOOKUP = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/dawg_victim_sel.sv
// dawg_victim_sel: picks the fill way for a miss -- lowest free allowed way, else the first
// allowed way at or above rr_ptr (wrapping).
module dawg_victim_sel
    import dawg_cache_set_pkg::*;
#(
    parameter int NUM_WAYS = DEF_NUM_WAYS,
    parameter int IW       = clog2_min1(NUM_WAYS)
) (
    input  logic [NUM_WAYS-1:0] valid,
    input  logic [NUM_WAYS-1:0] mask,
    input  logic [IW-1:0]       rr_ptr,
    output logic [NUM_WAYS-1:0] victim_oh,
    output logic [IW-1:0]       victim_idx,
    output logic                victim_any
);
    localparam logic [IW:0] NW = (IW+1)'(NUM_WAYS);
    logic [NUM_WAYS-1:0]   free;
    logic [2*NUM_WAYS-1:0] dbl;
    logic [NUM_WAYS-1:0]   rot;
    logic [IW-1:0]         free_idx, off, rr_idx;
    logic [IW:0]           rr_sum, rr_wrap;
    assign free = mask & ~valid;
    // rotating the mask right by rr_ptr turns the wrapped scan into a lowest-bit search
    assign dbl = {mask, mask} >> rr_ptr;
    assign rot = dbl[NUM_WAYS-1:0];
    always_comb begin
        free_idx = '0;
        off = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (free[i]) free_idx = IW'(i);
            if (rot[i]) off = IW'(i);
        end
    end
    assign rr_sum = {1'b0, rr_ptr} + {1'b0, off};
    assign rr_wrap = rr_sum - NW;
    assign rr_idx = (rr_sum >= NW) ? rr_wrap[IW-1:0] : rr_sum[IW-1:0];
    assign victim_any = |mask;
    assign victim_idx = (|free) ? free_idx : rr_idx;
    assign victim_oh = victim_any ? (NUM_WAYS'(1) << victim_idx) : '0;
endmodule

// File: rtl/dawg_cache_set.sv
// dawg_cache_set: one cache set with DAWG way partitioning across OS-programmed protection domains.
// Define DAWG_STATS_EN to add saturating per-domain hit/miss counters (stat_hits, stat_misses).
module dawg_cache_set
    import dawg_cache_set_pkg::*;
#(
    parameter int NUM_WAYS    = DEF_NUM_WAYS,
    parameter int NUM_DOMAINS = DEF_NUM_DOMAINS,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
`ifdef DAWG_STATS_EN
    parameter int STAT_WIDTH  = 16,
`endif
    parameter int DW          = clog2_min1(NUM_DOMAINS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  os_req_valid,
    output logic                  os_req_ready,
    input  logic [DW-1:0]         os_domain,
    input  logic [NUM_WAYS-1:0]   os_waymask,
    input  logic                  user_req_valid,
    output logic                  user_req_ready,
    input  logic [DW-1:0]         user_domain,
    input  logic [ADDR_WIDTH-1:0] user_addr,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic                  resp_hit,
    output logic [NUM_WAYS-1:0]   resp_hitmap,
    output logic                  resp_evict_valid,
    output logic [ADDR_WIDTH-1:0] resp_evict_addr
`ifdef DAWG_STATS_EN
    ,
    output logic [NUM_DOMAINS*STAT_WIDTH-1:0] stat_hits,
    output logic [NUM_DOMAINS*STAT_WIDTH-1:0] stat_misses
`endif
);
    localparam int IW = clog2_min1(NUM_WAYS);
    logic [1:0]            state;
    logic [NUM_WAYS-1:0]   valid;
    logic [ADDR_WIDTH-1:0] tag [NUM_WAYS];
    logic [NUM_WAYS-1:0]   waymask [NUM_DOMAINS];
    logic [IW-1:0]         rr_ptr [NUM_DOMAINS];
    logic [DW-1:0]         req_dom, os_dom;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [NUM_WAYS-1:0]   os_mask, dom_mask, match, vic_oh;
    logic [IW-1:0]         vic_idx, rr_next;
    logic                  hit, vic_any, fill, evict;
    assign os_req_ready = state == S_IDLE;
    assign user_req_ready = state == S_IDLE && !os_req_valid;
    assign resp_valid = state == S_RESP;
    assign dom_mask = waymask[req_dom];
    // a tag match outside the requester's mask must never count as a hit
    always_comb begin
        match = '0;
        for (int w = 0; w < NUM_WAYS; w++) match[w] = valid[w] && tag[w] == req_addr && dom_mask[w];
    end
    assign hit = |match;
    assign fill = state == S_LOOKUP && !hit && vic_any;
    assign evict = valid[vic_idx];
    assign rr_next = (vic_idx == IW'(NUM_WAYS - 1)) ? '0 : vic_idx + IW'(1);
    dawg_victim_sel #(.NUM_WAYS(NUM_WAYS), .IW(IW)) u_vsel (
        .valid      (valid),
        .mask       (dom_mask),
        .rr_ptr     (rr_ptr[req_dom]),
        .victim_oh  (vic_oh),
        .victim_idx (vic_idx),
        .victim_any (vic_any)
    );
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            valid <= '0;
            req_dom <= '0;
            req_addr <= '0;
            os_dom <= '0;
            os_mask <= '0;
            resp_hit <= 1'b0;
            resp_hitmap <= '0;
            resp_evict_valid <= 1'b0;
            resp_evict_addr <= '0;
            for (int d = 0; d < NUM_DOMAINS; d++) begin
                waymask[d] <= {NUM_WAYS{d == 0}};
                rr_ptr[d] <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (os_req_valid) begin
                        os_dom <= os_domain;
                        os_mask <= os_waymask;
                        state <= S_OS_UPD;
                    end else if (user_req_valid) begin
                        req_dom <= user_domain;
                        req_addr <= user_addr;
                        state <= S_LOOKUP;
                    end
                end
                S_OS_UPD: begin
                    valid <= valid & ~(waymask[os_dom] & ~os_mask);
                    waymask[os_dom] <= os_mask;
                    state <= S_IDLE;
                end
                S_LOOKUP: begin
                    resp_hit <= hit;
                    resp_hitmap <= hit ? match : vic_oh;
                    resp_evict_valid <= fill && evict;
                    resp_evict_addr <= (fill && evict) ? tag[vic_idx] : '0;
                    if (fill) begin
                        valid[vic_idx] <= 1'b1;
                        if (evict) rr_ptr[req_dom] <= rr_next;
                    end
                    state <= S_RESP;
                end
                default: if (resp_ready) state <= S_IDLE;
            endcase
        end
    end
    always_ff @(posedge clk) if (fill) tag[vic_idx] <= req_addr;
`ifdef DAWG_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_hits <= '0;
            stat_misses <= '0;
        end else if (state == S_LOOKUP) begin
            for (int d = 0; d < NUM_DOMAINS; d++) begin
                if (int'(req_dom) == d && hit && !(&stat_hits[d*STAT_WIDTH +: STAT_WIDTH]))
                    stat_hits[d*STAT_WIDTH +: STAT_WIDTH] <= stat_hits[d*STAT_WIDTH +: STAT_WIDTH] + STAT_WIDTH'(1);
                if (int'(req_dom) == d && !hit && !(&stat_misses[d*STAT_WIDTH +: STAT_WIDTH]))
                    stat_misses[d*STAT_WIDTH +: STAT_WIDTH] <= stat_misses[d*STAT_WIDTH +: STAT_WIDTH] + STAT_WIDTH'(1);
            end
        end
    end
`endif
endmodule

// File: tb/tb_dawg_cache_set.sv
// tb_dawg_cache_set: directed scenarios plus randomized traffic checked against a behavioural
// model of a 4-way, 2-domain DAWG set.
module tb_dawg_cache_set;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        os_req_valid = 1'b0;
    logic        os_req_ready;
    logic [0:0]  os_domain = '0;
    logic [3:0]  os_waymask = '0;
    logic        user_req_valid = 1'b0;
    logic        user_req_ready;
    logic [0:0]  user_domain = '0;
    logic [31:0] user_addr = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic        resp_hit;
    logic [3:0]  resp_hitmap;
    logic        resp_evict_valid;
    logic [31:0] resp_evict_addr;
`ifdef DAWG_STATS_EN
    logic [31:0] stat_hits, stat_misses;
`endif
    int checks = 0;
    int failures = 0;
    bit          m_valid [4];
    logic [31:0] m_tag [4];
    logic [3:0]  m_mask [2];
    int          m_rr [2];

    dawg_cache_set dut (
        .clk              (clk),
        .reset            (reset),
        .os_req_valid     (os_req_valid),
        .os_req_ready     (os_req_ready),
        .os_domain        (os_domain),
        .os_waymask       (os_waymask),
        .user_req_valid   (user_req_valid),
        .user_req_ready   (user_req_ready),
        .user_domain      (user_domain),
        .user_addr        (user_addr),
        .resp_valid       (resp_valid),
        .resp_ready       (resp_ready),
        .resp_hit         (resp_hit),
        .resp_hitmap      (resp_hitmap),
        .resp_evict_valid (resp_evict_valid),
        .resp_evict_addr  (resp_evict_addr)
`ifdef DAWG_STATS_EN
        ,
        .stat_hits        (stat_hits),
        .stat_misses      (stat_misses)
`endif
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        for (int w = 0; w < 4; w++) m_valid[w] = 1'b0;
        m_mask[0] = 4'hF;
        m_mask[1] = 4'h0;
        m_rr[0] = 0;
        m_rr[1] = 0;
    endtask

    task automatic model_os(input int d, input logic [3:0] m);
        for (int w = 0; w < 4; w++) if (m_mask[d][w] && !m[w]) m_valid[w] = 1'b0;
        m_mask[d] = m;
    endtask

    // result packed as {hit, hitmap[3:0], evict_valid, evict_addr[31:0]}
    task automatic model_lookup(input int d, input logic [31:0] a, output logic [37:0] exp);
        logic h, ev;
        logic [3:0] hm;
        logic [31:0] ea;
        int v, w2;
        h = 0; hm = 0; ev = 0; ea = 0; v = -1;
        for (int w = 0; w < 4; w++)
            if (m_valid[w] && m_tag[w] == a && m_mask[d][w]) begin h = 1; hm = 4'(1 << w); end
        if (!h && m_mask[d] != 0) begin
            for (int w = 0; w < 4; w++) if (v < 0 && m_mask[d][w] && !m_valid[w]) v = w;
            for (int k = 0; k < 4; k++) begin
                w2 = (m_rr[d] + k) % 4;
                if (v < 0 && m_mask[d][w2]) v = w2;
            end
            hm = 4'(1 << v);
            if (m_valid[v]) begin ev = 1; ea = m_tag[v]; m_rr[d] = (v + 1) % 4; end
            m_valid[v] = 1'b1;
            m_tag[v] = a;
        end
        exp = {h, hm, ev, ea};
    endtask

    task automatic do_os(input int d, input logic [3:0] m);
        int n;
        @(negedge clk);
        os_req_valid = 1'b1; os_domain = d[0]; os_waymask = m;
        n = 0;
        while (!os_req_ready && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); #1 os_req_valid = 1'b0;
    endtask

    task automatic do_lookup(input int d, input logic [31:0] a, input int stall,
                             output logic [37:0] got, output int lat);
        int n;
        @(negedge clk);
        user_req_valid = 1'b1; user_domain = d[0]; user_addr = a;
        n = 0;
        while (!user_req_ready && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); #1 user_req_valid = 1'b0;
        lat = 0;
        while (!resp_valid && lat < 20) begin @(negedge clk); lat++; end
        if (!resp_valid) lat = -1;
        got = {resp_hit, resp_hitmap, resp_evict_valid, resp_evict_addr};
        repeat (stall) @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk); #1 resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({os_req_ready, user_req_ready, resp_valid} !== 3'b110) begin
            failures++; $display("FAIL reset_ready got=%b exp=110", {os_req_ready, user_req_ready, resp_valid});
        end
        checks++;
        if ({resp_hit, resp_hitmap, resp_evict_valid, resp_evict_addr} !== 38'd0) begin
            failures++; $display("FAIL reset_fields got=%h exp=0", {resp_hit, resp_hitmap, resp_evict_valid, resp_evict_addr});
        end
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        checks++;
        if ({os_req_ready, user_req_ready, resp_valid} !== 3'b110) begin
            failures++; $display("FAIL post_reset_ready got=%b exp=110", {os_req_ready, user_req_ready, resp_valid});
        end
    endtask

    task automatic test_fill();
        logic [37:0] got, exp;
        int lat;
        for (int i = 1; i <= 4; i++) begin
            model_lookup(0, 32'(i * 256), exp);
            do_lookup(0, 32'(i * 256), 0, got, lat);
            checks++;
            if (got !== exp) begin failures++; $display("FAIL fill_%0d got=%h exp=%h", i, got, exp); end
            checks++;
            if (got[37:32] !== {1'b0, 4'(1 << (i - 1)), 1'b0}) begin
                failures++; $display("FAIL fill_way_%0d got=%b exp=%b", i, got[37:32], {1'b0, 4'(1 << (i - 1)), 1'b0});
            end
            checks++;
            if (lat !== 2) begin failures++; $display("FAIL fill_latency got=%0d exp=2", lat); end
        end
        model_lookup(0, 32'h200, exp);
        do_lookup(0, 32'h200, 0, got, lat);
        checks++;
        if (got !== exp) begin failures++; $display("FAIL rehit got=%h exp=%h", got, exp); end
        checks++;
        if (got[37:33] !== 5'b10010) begin failures++; $display("FAIL rehit_map got=%b exp=10010", got[37:33]); end
`ifdef DAWG_STATS_EN
        checks++;
        if ({stat_hits[15:0], stat_misses[15:0]} !== {16'd1, 16'd4}) begin
            failures++; $display("FAIL stats got=%0d/%0d exp=1/4", stat_hits[15:0], stat_misses[15:0]);
        end
`endif
    endtask

    task automatic test_evict();
        logic [37:0] got, exp;
        int lat;
        model_lookup(0, 32'h500, exp);
        do_lookup(0, 32'h500, 0, got, lat);
        checks++;
        if (got !== exp) begin failures++; $display("FAIL evict_500 got=%h exp=%h", got, exp); end
        checks++;
        if (got !== {1'b0, 4'b0001, 1'b1, 32'h100}) begin failures++; $display("FAIL evict_500_const got=%h", got); end
        model_lookup(0, 32'h600, exp);
        do_lookup(0, 32'h600, 0, got, lat);
        checks++;
        if (got !== {1'b0, 4'b0010, 1'b1, 32'h200} || got !== exp) begin
            failures++; $display("FAIL evict_600 got=%h exp=%h", got, exp);
        end
    endtask

    task automatic test_realloc();
        logic [37:0] got, exp;
        int lat;
        do_os(0, 4'b0011); model_os(0, 4'b0011);
        do_os(1, 4'b1100); model_os(1, 4'b1100);
        model_lookup(1, 32'h300, exp);
        do_lookup(1, 32'h300, 0, got, lat);
        checks++;
        if (got !== exp || got[37:32] !== 6'b001000) begin
            failures++; $display("FAIL realloc_dom1 got=%h exp=%h", got, exp);
        end
        model_lookup(0, 32'h300, exp);
        do_lookup(0, 32'h300, 0, got, lat);
        checks++;
        if (got !== exp || got[37] !== 1'b0) begin
            failures++; $display("FAIL realloc_dom0 got=%h exp=%h", got, exp);
        end
    endtask

    task automatic test_bypass();
        logic [37:0] got, exp;
        int lat;
        do_os(1, 4'b0000); model_os(1, 4'b0000);
        model_lookup(1, 32'h700, exp);
        do_lookup(1, 32'h700, 0, got, lat);
        checks++;
        if (got !== exp || got[37:32] !== 6'd0) begin
            failures++; $display("FAIL bypass got=%h exp=%h", got, exp);
        end
        model_lookup(0, 32'h600, exp);
        do_lookup(0, 32'h600, 0, got, lat);
        checks++;
        if (got !== exp) begin failures++; $display("FAIL bypass_intact got=%h exp=%h", got, exp); end
    endtask

    task automatic test_priority();
        logic [37:0] got, exp;
        int n, lat;
        @(negedge clk);
        os_req_valid = 1'b1; os_domain = 1'b1; os_waymask = 4'b1100;
        user_req_valid = 1'b1; user_domain = 1'b1; user_addr = 32'h800;
        #1;
        checks++;
        if ({os_req_ready, user_req_ready} !== 2'b10) begin
            failures++; $display("FAIL prio_ready got=%b exp=10", {os_req_ready, user_req_ready});
        end
        @(posedge clk); #1 os_req_valid = 1'b0;
        model_os(1, 4'b1100);
        n = 0;
        do begin @(negedge clk); n++; end while (!user_req_ready && n < 10);
        checks++;
        if (n !== 2) begin failures++; $display("FAIL prio_user_delay got=%0d exp=2", n); end
        @(posedge clk); #1 user_req_valid = 1'b0;
        lat = 0;
        while (!resp_valid && lat < 20) begin @(negedge clk); lat++; end
        got = {resp_hit, resp_hitmap, resp_evict_valid, resp_evict_addr};
        model_lookup(1, 32'h800, exp);
        checks++;
        if (got !== exp || !resp_valid) begin failures++; $display("FAIL prio_result got=%h exp=%h", got, exp); end
        resp_ready = 1'b1;
        @(posedge clk); #1 resp_ready = 1'b0;
    endtask

    task automatic test_stall_and_reset();
        logic [37:0] got, exp;
        int n, lat;
        @(negedge clk);
        user_req_valid = 1'b1; user_domain = 1'b0; user_addr = 32'h900;
        n = 0;
        while (!user_req_ready && n < 20) begin @(negedge clk); n++; end
        @(posedge clk); #1 user_req_valid = 1'b0;
        lat = 0;
        while (!resp_valid && lat < 20) begin @(negedge clk); lat++; end
        got = {resp_hit, resp_hitmap, resp_evict_valid, resp_evict_addr};
        model_lookup(0, 32'h900, exp);
        checks++;
        if (got !== exp || !resp_valid) begin failures++; $display("FAIL stall_result got=%h exp=%h", got, exp); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({resp_hit, resp_hitmap, resp_evict_valid, resp_evict_addr, resp_valid, os_req_ready, user_req_ready} !== {exp, 3'b100}) begin
                failures++; $display("FAIL stall_hold_%0d got=%h exp=%h", i,
                    {resp_hit, resp_hitmap, resp_evict_valid, resp_evict_addr, resp_valid, os_req_ready, user_req_ready}, {exp, 3'b100});
            end
        end
        resp_ready = 1'b1;
        @(posedge clk); #1 resp_ready = 1'b0;
        @(negedge clk);
        user_req_valid = 1'b1; user_domain = 1'b0; user_addr = 32'hA00;
        @(posedge clk); #1 user_req_valid = 1'b0;
        #2 reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({resp_valid, os_req_ready, user_req_ready, resp_hit, resp_hitmap, resp_evict_valid, resp_evict_addr} !== {3'b011, 38'd0}) begin
            failures++; $display("FAIL midreset_outputs got=%h", {resp_valid, os_req_ready, user_req_ready, resp_hit, resp_hitmap, resp_evict_valid, resp_evict_addr});
        end
        reset = 1'b1;
        model_reset();
        n = 0;
        repeat (3) begin @(negedge clk); if (resp_valid) n++; end
        checks++;
        if (n !== 0) begin failures++; $display("FAIL midreset_no_resp got=%0d exp=0", n); end
        model_lookup(0, 32'h100, exp);
        do_lookup(0, 32'h100, 0, got, lat);
        checks++;
        if (got !== exp) begin failures++; $display("FAIL after_reset_dom0 got=%h exp=%h", got, exp); end
        model_lookup(1, 32'h100, exp);
        do_lookup(1, 32'h100, 0, got, lat);
        checks++;
        if (got !== exp) begin failures++; $display("FAIL after_reset_dom1 got=%h exp=%h", got, exp); end
    endtask

    task automatic test_random();
        logic [37:0] got, exp;
        logic [3:0] m;
        logic [31:0] a;
        int d, lat;
        for (int i = 0; i < 300; i++) begin
            d = int'($urandom_range(0, 1));
            if ($urandom_range(0, 4) == 0) begin
                m = 4'($urandom_range(0, 15));
                do_os(d, m);
                model_os(d, m);
            end else begin
                a = 32'($urandom_range(1, 10) * 256);
                model_lookup(d, a, exp);
                do_lookup(d, a, int'($urandom_range(0, 2)), got, lat);
                checks++;
                if (got !== exp || lat !== 2) begin
                    failures++; $display("FAIL rand_%0d dom=%0d addr=%h got=%h lat=%0d exp=%h lat=2", i, d, a, got, lat, exp);
                end
            end
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_fill();
        test_evict();
        test_realloc();
        test_bypass();
        test_priority();
        test_stall_and_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
